// File: rtl/conv3x3_stream_ctrl.sv
// Stream sequencer for a 3x3 convolution datapath: builds sliding windows from a raster
// pixel stream with two line buffers and returns one registered result per window.
module conv3x3_stream_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        w_valid,
    input  logic [7:0]  w_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    output logic [71:0] conv_in,
    output logic [71:0] conv_w,
    input  logic [18:0] conv_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] out_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    w   [9];
    logic [3:0]    w_idx;
    logic          w_loaded;
    logic [7:0]    win [9];
    logic          win_valid;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];

    logic stall;
    logic accept;
    logic last_pix;
    logic drain_done;
    logic go;

    assign stall      = out_valid && !out_ready;
    assign pix_ready  = (state == RUN) && !stall;
    assign accept     = pix_valid && pix_ready;
    assign last_pix   = accept && (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
    // Empty once no window is pending and the held result (if any) leaves this cycle.
    assign drain_done = (state == DRAIN) && !win_valid && (!out_valid || out_ready);
    assign go         = (state == IDLE) && start && w_loaded;
    assign busy       = (state != IDLE);

    always_comb begin
        conv_in = '0;
        conv_w  = '0;
        for (int k = 0; k < 9; k++) begin
            conv_in[8*k +: 8] = win[k];
            conv_w[8*k +: 8]  = w[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:    if (go) state <= RUN;
                RUN:     if (last_pix) state <= DRAIN;
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) w[k] <= '0;
            w_idx    <= '0;
            w_loaded <= 1'b0;
        end else if ((state == IDLE) && w_valid) begin
            w[w_idx] <= w_data;
            if (w_idx == 4'd8) begin
                w_idx    <= '0;
                w_loaded <= 1'b1;
            end else begin
                w_idx <= w_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (go) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Accept implies no stall, so the window only moves while the output stage is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) win[k] <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r + 1];
                win[3*r + 1] <= win[3*r + 2];
            end
            win[2]   <= lb1[col];
            win[5]   <= lb0[col];
            win[8]   <= pix_data;
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
            out_valid <= win_valid;
            if (win_valid) out_data <= conv_result;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Directed bench for conv3x3_stream_ctrl on a 4x4 image with a behavioural multiply-add datapath.
module tb_conv3x3_stream_ctrl;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        w_valid = 1'b0;
    logic [7:0]  w_data = '0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        pix_ready;
    logic        out_valid;
    logic [71:0] conv_in;
    logic [71:0] conv_w;
    logic [18:0] conv_result;
    logic [18:0] out_data;

    int checks = 0;
    int failures = 0;

    conv3x3_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .conv_in     (conv_in),
        .conv_w      (conv_w),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        conv_result = '0;
        for (int k = 0; k < 9; k++) begin
            conv_result = conv_result + 19'(conv_in[8*k +: 8]) * 19'(conv_w[8*k +: 8]);
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_w(input logic [71:0] wv, input int beats);
        for (int k = 0; k < beats; k++) begin
            w_valid = 1'b1;
            w_data  = wv[8*k +: 8];
            tick();
        end
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    // Pixel i of the frame is base + i*step; e0..e3 are the expected results in order.
    task automatic run_frame(input int base, input int step, input int stall_len,
                             input bit chk_lat, input int e0, input int e1,
                             input int e2, input int e3);
        int exp_v [4];
        int pi = 0;
        int nout = 0;
        int ndone = 0;
        int post = 0;
        int stall_left = stall_len;
        int acc10 = -1;
        int ov1 = -1;
        exp_v = '{e0, e1, e2, e3};
        pulse_start();
        for (int c = 0; c < 300 && post < 3; c++) begin
            pix_valid = (pi < W * H);
            pix_data  = 8'(base + pi * step);
            out_ready = 1'b1;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            @(negedge clk);
            if (!out_ready) begin
                chk("stall_pix_ready", 72'(pix_ready), 72'(0));
                chk("stall_hold", 72'(out_data), 72'(exp_v[0]));
            end
            if (pix_valid && pix_ready) begin
                if (pi == 10) acc10 = c;
                pi++;
            end
            if (out_valid && ov1 < 0) ov1 = c;
            if (out_valid && out_ready) begin
                if (nout < 4) chk("out_data", 72'(out_data), 72'(exp_v[nout]));
                nout++;
            end
            if (done) ndone++;
            if (ndone > 0) post++;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        chk("pix_count", 72'(pi), 72'(W * H));
        chk("out_count", 72'(nout), 72'(4));
        chk("done_count", 72'(ndone), 72'(1));
        chk("busy_after", 72'(busy), 72'(0));
        // Accept is sampled the cycle before its edge; out_valid shows one edge later still.
        if (chk_lat) chk("latency", 72'(ov1 - acc10), 72'(2));
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        chk("rst_pix_ready", 72'(pix_ready), 72'(0));
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_out_data", 72'(out_data), 72'(0));
        chk("rst_conv_w", conv_w, 72'(0));
        chk("rst_conv_in", conv_in, 72'(0));
        rst_n = 1'b1;
        tick();

        // start without weights, then with only 8 beats: both ignored
        pulse_start();
        chk("start_no_w", 72'(busy), 72'(0));
        load_w({9{8'd1}}, 8);
        pulse_start();
        chk("start_8_beats", 72'(busy), 72'(0));
        load_w({9{8'd1}}, 1);
        chk("conv_w_9_beats", conv_w, {9{8'd1}});
        pulse_start();
        chk("start_9_beats", 72'(busy), 72'(1));

        // abort mid-frame after 8 pixels
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(i);
            tick();
        end
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 72'(busy), 72'(0));
        chk("abort_done", 72'(done), 72'(0));
        chk("abort_out_valid", 72'(out_valid), 72'(0));
        chk("abort_conv_w", conv_w, 72'(0));
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        chk("start_after_abort", 72'(busy), 72'(0));
        chk("no_done_after_abort", 72'(done), 72'(0));

        // all-ones weights and pixels
        load_w({9{8'd1}}, 9);
        run_frame(1, 0, 0, 1'b0, 9, 9, 9, 9);

        // centre tap only, pixels 0..15
        load_w(72'd1 << 32, 9);
        chk("conv_w_center", conv_w, 72'd1 << 32);
        run_frame(0, 1, 0, 1'b1, 5, 6, 9, 10);

        // same with a 5-cycle stall on the first result
        run_frame(0, 1, 5, 1'b0, 5, 6, 9, 10);

        // top-left tap, new pixel values: no stale line-buffer data may leak
        load_w(72'd1, 9);
        run_frame(100, 1, 0, 1'b0, 100, 101, 104, 105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream_ctrl.md
Name: conv3x3_stream_ctrl

Overview:
Sequencer for the 3x3 convolution datapath (9 pixel inputs, 9 weight inputs, 19-bit combinational result). It accepts a raster-order 8-bit pixel stream and a 9-beat weight load, and builds sliding 3x3 windows using two line buffers. It drives each window into the datapath and emits one registered result per valid window position with valid/ready backpressure. Stride is 1 and there is no padding, so each frame yields (IMG_W-2)*(IMG_H-2) outputs.

Parameters:
IMG_W, 28, image width in pixels (>=3)
IMG_H, 28, image height in pixels (>=3)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse after the frame's last output transfer
w_valid  in  1  weight beat strobe
w_data  in  8  weight value; beat k loads w[k]
pix_valid  in  1  pixel available
pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
pix_data  in  8  pixel, raster order
conv_in  out  72  window; conv_in[8k+7:8k]=pixel k, k=3*row+col, row0=top, col0=left/oldest
conv_w  out  72  weights; conv_w[8k+7:8k]=w[k]
conv_result  in  19  datapath result for conv_in/conv_w (combinational)
out_valid  out  1  result available
out_ready  in  1  downstream accept
out_data  out  19  registered conv_result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, pix_ready and out_valid = 0; out_data=0; window, weights, line buffers, counters and w_idx = 0; w_loaded=0. Reset mid-frame aborts the frame with no done pulse, and weights must be reloaded.
- States: IDLE -> RUN on start&&w_loaded. RUN -> DRAIN after the IMG_W*IMG_H-th pixel is accepted. DRAIN -> IDLE once the pipeline is empty and the final out transfer completes, with done=1 for one cycle on that transition.
- start is ignored when !w_loaded or when not IDLE.
- Weight load (IDLE only; w_valid ignored in other states): each w_valid beat writes w[w_idx] and increments w_idx. Beat 9 sets w_loaded=1 and wraps w_idx to 0. A new load overwrites weights in order. conv_w is the registered weights.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each pixel accept; col wraps to 0 and row increments. Both clear on start.
- Line buffers lb0 and lb1, IMG_W x 8 each. On accept at column col: window shifts left one column; new right column = {top=lb1[col], mid=lb0[col], bot=pix_data}; lb1[col]<=lb0[col]; lb0[col]<=pix_data.
- win_valid <= accept && row>=2 && col>=2, evaluated with pre-increment counters.
- Pipeline: stall = out_valid && !out_ready. pix_ready = (state==RUN) && !stall.
  - When !stall: out_valid<=win_valid; out_data<=conv_result if win_valid.
  - When stall: window, win_valid and out hold.
- Latency: a pixel that completes a window, accepted at edge k, gives out_valid=1 after edge k+1 (assuming no stall).
- out_data is exactly conv_result with no saturation; overflow is owned by the datapath.
- Between frames the line buffers retain stale data; they are never read before being overwritten because win_valid requires row>=2.

Test Plan:
- IMG_W=IMG_H=4, weights all 1, pixels all 1, out_ready=1 -> exactly 4 outputs, each 9. done pulses once; busy=0 afterwards.
- IMG_W=IMG_H=4, w[4]=1 and others 0, pixels 0..15 -> outputs 5, 6, 9, 10 in order. The first out_valid appears 1 cycle after accepting pixel 10.
- Same as the previous case with out_ready held 0 for 5 cycles at the first output -> pix_ready=0 during the stall, out_data holds 5, and no result is lost or duplicated.
- start before any weight load, then only 8 w_valid beats, then start -> both starts ignored, busy stays 0. A 9th beat followed by start enters RUN.
- Assert rst_n=0 after pixel 7 of a frame -> all outputs 0, no done pulse. A subsequent start is ignored until weights are reloaded.
- Two back-to-back 4x4 frames, the second with pixels 100..115 and w[0]=1 -> second-frame outputs 100, 101, 104, 105, with no stale data from frame one.
